uart_rx_mv_sampler: RTL
=======================

# uart_rx_mv_sampler

Parametrised majority-vote bit sampler for the UART receiver, successor to the fixed 3-sample sampler. It sits between the RX edge/bit counter and the deserializer/parity/stop checkers. It captures an odd, configurable number of oversamples centred on the bit, votes, and reports each decision with a valid strobe. It also flags noise (disagreeing samples) and unusable prescale settings, and contains an optional input synchronizer.

## Interface
- PRESCALE_W, 6: width of `prescale` and `edge_cnt`.
- NUM_SAMPLES, 3: samples per bit; odd, legal range 1..7 (elaboration error otherwise).
- SYNC_STAGES, 2: flops on `RX_IN` before sampling; 0 = bypass.

Ports:
- clk  in  1  oversampling clock.
- rst  in  1  reset, synchronous, active-high.
- data_samp_en  in  1  sampling enable from the RX FSM.
- RX_IN  in  1  serial line, idle high.
- prescale  in  PRESCALE_W  oversampling ratio.
- edge_cnt  in  PRESCALE_W  oversample index within the current bit, 0..prescale-1.
- sampled_bit  out  1  voted bit value.
- sample_valid  out  1  one-cycle strobe: `sampled_bit` updated.
- noise_err  out  1  qualified by `sample_valid`: the samples were not unanimous.
- cfg_err  out  1  level: `prescale` cannot host the sample window.

## Operation
- Centre c = prescale>>1.
- Window = edge_cnt values c-(NUM_SAMPLES-1) .. c inclusive.
- Vote point = edge_cnt == c+1.
- All window arithmetic uses PRESCALE_W+1 bits, so the window start never wraps.
- cfg_err is registered and recomputed every cycle: 1 when c < NUM_SAMPLES-1 or prescale < 4. While it is 1, no captures occur and sample_valid stays 0.
- Sampling uses `rx_s`, the synchronized RX (`RX_IN` delayed SYNC_STAGES cycles). Aligning `edge_cnt` with that delay is the upstream counter's job.
- Capture: shift `rx_s` into an NUM_SAMPLES-bit shift register and increment `samp_cnt`. This happens only when all of the following hold:
  - data_samp_en = 1;
  - cfg_err = 0;
  - edge_cnt is inside the window;
  - edge_cnt differs from its value in the previous cycle (edge-change detect, so a held `edge_cnt` captures once).
- Vote: happens on the first cycle at the vote point with data_samp_en = 1 and samp_cnt == NUM_SAMPLES.
  - sampled_bit ← popcount(sr) > NUM_SAMPLES/2.
  - noise_err ← (sr ≠ all-0) and (sr ≠ all-1).
  - sample_valid ← 1 for one cycle.
- samp_cnt clears on a vote, on edge_cnt == 0, or whenever data_samp_en = 0. If enable drops mid-window, the bit is aborted: no valid is produced.
- An incomplete window (samp_cnt < NUM_SAMPLES) at the vote point produces no valid.
- Simultaneous case: edge_cnt == 0 together with a vote is impossible, since the vote point is ≥ 3.
- Between votes, sampled_bit and noise_err hold their last values.

## Timing
- Reset values:
  - sampled_bit = 1, sample_valid = 0, noise_err = 0, cfg_err = 0;
  - sync chain = all 1;
  - sr = 0, samp_cnt = 0;
  - previous-edge register = all 1 (so edge_cnt = 0 after reset is seen as a change).
- Reset asserted mid-window abandons the window. All outputs show reset values on the cycle after rst is sampled high.
- Outputs are registered. sample_valid rises one cycle after the clk edge that samples edge_cnt == c+1.
- Pin-to-capture latency: SYNC_STAGES cycles.
- Vote throughput: at most one per bit period.
- prescale may change only while data_samp_en = 0. cfg_err reflects a new value one cycle later.

## Structure
- Package `uart_rx_pkg`:
  - default PRESCALE_W;
  - MAX_SAMPLES = 7;
  - function `maj_vote(sr, n)` returning {bit, noise}.
- Sub-module `rx_bit_sync`: SYNC_STAGES-deep flop chain, reset to 1, pure wire when SYNC_STAGES = 0.
- Top-level parts: window decode, edge-change detect, shift register/counter, vote register, cfg check.

## Test plan
- prescale=8, N=3, RX_IN=1 steady, edge_cnt 0..7 per bit, en=1:
  - captures at edges 2,3,4;
  - valid one cycle after edge 5;
  - bit=1, noise=0.
- Same config, RX=0 only during edge 2 → bit=1, noise=1. RX=0 during edges 2 and 3 → bit=0, noise=1.
- N=5, prescale=16 (window 4..8, vote at 9):
  - two zeros → bit=1, noise=1;
  - three zeros → bit=0;
  - all zeros → bit=0, noise=0.
- en dropped at edge 3 and restored at edge 4 → no valid for that bit. The next bit votes normally.
- N=3, prescale=2 → cfg_err=1 the following cycle, no valid over 20 bits. prescale=8 → cfg_err=0 one cycle later.
- rst pulsed during edge 3 with SYNC_STAGES=2:
  - outputs at reset values next cycle, sync chain reads 1;
  - no valid for the aborted bit.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants and majority-vote helper for the UART receiver
package uart_rx_pkg;

  localparam int PRESCALE_W_DEF = 6;
  localparam int MAX_SAMPLES    = 7;

  // Returns {voted_bit, noise}; only the low n bits of sr take part.
  function automatic logic [1:0] maj_vote(input logic [MAX_SAMPLES-1:0] sr, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < MAX_SAMPLES; i++) begin
      if (i < n && sr[i]) ones++;
    end
    return {(ones > n / 2), ((ones != 0) && (ones != n))};
  endfunction

endpackage

// File: rtl/rx_bit_sync.sv
// rtl/rx_bit_sync.sv - idle-high flop chain synchronizer for the serial line
module rx_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  if (STAGES == 0) begin : g_bypass
    assign rx_s = rx;
  end else begin : g_chain
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
      if (rst) chain <= '1;
      else     chain <= (chain << 1) | STAGES'(rx);
    end

    assign rx_s = chain[STAGES-1];
  end

endmodule

// File: rtl/uart_rx_mv_sampler.sv
// rtl/uart_rx_mv_sampler.sv - centred N-sample majority-vote bit sampler with noise/config flags
module uart_rx_mv_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = PRESCALE_W_DEF,
  parameter int NUM_SAMPLES = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_samp_en,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_err,
  output logic                  cfg_err
);

  localparam int W1 = PRESCALE_W + 1;
  localparam int CW = $clog2(MAX_SAMPLES + 1);
  localparam logic [W1-1:0] NM1  = W1'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_SAMPLES);

  if ((NUM_SAMPLES % 2) == 0 || NUM_SAMPLES < 1 || NUM_SAMPLES > MAX_SAMPLES) begin : g_bad_n
    $error("uart_rx_mv_sampler: NUM_SAMPLES must be odd and within 1..7");
  end

  logic rx_s;

  rx_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (RX_IN),
    .rx_s (rx_s)
  );

  // Window decode in one extra bit; start compared as edge+(N-1) >= c so nothing wraps.
  logic [W1-1:0] ps_x, edge_x, centre;
  logic          in_win, vote_pt, cfg_bad;

  assign ps_x    = {1'b0, prescale};
  assign edge_x  = {1'b0, edge_cnt};
  assign centre  = ps_x >> 1;
  assign in_win  = ((edge_x + NM1) >= centre) && (edge_x <= centre);
  assign vote_pt = (edge_x == (centre + W1'(1)));
  assign cfg_bad = (centre < NM1) || (ps_x < W1'(4));

  logic [PRESCALE_W-1:0]  prev_edge;
  logic [NUM_SAMPLES-1:0] sr, sr_next;
  logic [CW-1:0]          samp_cnt;
  logic                   capture, vote;
  logic [1:0]             vote_res;

  assign capture  = data_samp_en && !cfg_err && in_win && (edge_cnt != prev_edge);
  assign vote     = data_samp_en && !cfg_err && vote_pt && (samp_cnt == FULL);
  assign vote_res = maj_vote(MAX_SAMPLES'(sr), NUM_SAMPLES);

  always_comb begin
    sr_next    = sr << 1;
    sr_next[0] = rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_edge <= '1;
      cfg_err   <= 1'b0;
    end else begin
      prev_edge <= edge_cnt;
      cfg_err   <= cfg_bad;
    end
  end

  // A window starting at edge 0 restarts the count and still keeps that first sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      samp_cnt <= '0;
    end else begin
      if (capture) sr <= sr_next;
      if (!data_samp_en || vote)  samp_cnt <= '0;
      else if (edge_cnt == '0)    samp_cnt <= capture ? CW'(1) : '0;
      else if (capture)           samp_cnt <= samp_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sampled_bit  <= 1'b1;
      noise_err    <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= vote;
      if (vote) begin
        sampled_bit <= vote_res[1];
        noise_err   <= vote_res[0];
      end
    end
  end

endmodule
